// File: rtl/fsm_seq_driver.sv
// fsm_seq_driver: host-side stimulus/response sequencer for the control FSM.
//
// A program of up to DEPTH 4-bit vectors is loaded through ld_valid/ld_ready, then
// played back on i1..i4 one vector per clock after start. Each FSM response
// {err,n_o1,o2,o3,o4} is sampled RSP_LAT edges after its vector appeared and stored
// in a capture buffer readable through rd_en/rd_addr/rd_data (1-cycle latency).
//
// Ports:
//   clk, n_rst              clock (rising edge), asynchronous active-low reset
//   ld_valid, ld_data       stimulus load; ld_data[3]=i1 .. ld_data[0]=i4
//   ld_ready                load accepted when ld_valid && ld_ready
//   clr                     clears the loaded program (idle only)
//   start                   run request (idle only)
//   i1..i4                  registered drive to the FSM inputs
//   err, n_o1, o2, o3, o4   FSM outputs
//   rd_en, rd_addr, rd_data capture-buffer read port
//   count                   number of loaded vectors
//   busy, done              not-idle flag, end-of-run pulse
//   err_seen, err_idx       first captured err=1 of the run and its vector index

module fsm_seq_driver #(
    parameter int unsigned DEPTH       = 16,
    parameter int unsigned AW          = 4,
    parameter int unsigned RSP_LAT     = 1,
    parameter int unsigned STOP_ON_ERR = 1
) (
    input  logic          clk,
    input  logic          n_rst,
    input  logic          ld_valid,
    input  logic [3:0]    ld_data,
    output logic          ld_ready,
    input  logic          clr,
    input  logic          start,
    output logic          i1,
    output logic          i2,
    output logic          i3,
    output logic          i4,
    input  logic          err,
    input  logic          n_o1,
    input  logic          o2,
    input  logic          o3,
    input  logic          o4,
    input  logic          rd_en,
    input  logic [AW-1:0] rd_addr,
    output logic [4:0]    rd_data,
    output logic [AW:0]   count,
    output logic          busy,
    output logic          done,
    output logic          err_seen,
    output logic [AW-1:0] err_idx
);

    typedef enum logic [1:0] {StIdle, StRun, StDrain, StFin} state_t;

    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);
    localparam logic [AW:0] ONE  = {{AW{1'b0}}, 1'b1};

    state_t             state;
    logic [3:0]         stim_mem [DEPTH];
    logic [4:0]         rsp_mem  [DEPTH];
    logic [AW:0]        vec_ptr;
    logic [AW:0]        cap_ptr;
    // vld_sr[j] set means the vector driven j edges ago is still awaiting capture.
    logic [RSP_LAT-1:0] vld_sr;

    logic       ld_acc;
    logic       cap_fire;
    logic       first_err;
    logic       abort;
    logic [4:0] rsp_in;
    logic [3:0] vec0;

    assign busy      = (state != StIdle);
    assign ld_ready  = (state == StIdle) && (count < FULL);
    assign ld_acc    = (state == StIdle) && !clr && ld_valid && ld_ready;
    assign cap_fire  = vld_sr[RSP_LAT-1];
    assign rsp_in    = {err, n_o1, o2, o3, o4};
    assign first_err = cap_fire && err && !err_seen;
    assign abort     = first_err && (STOP_ON_ERR != 0);
    // A load accepted with start on an empty buffer is vector 0 itself.
    assign vec0      = (count == '0) ? ld_data : stim_mem[0];

    always_ff @(posedge clk) begin
        if (ld_acc) begin
            stim_mem[count[AW-1:0]] <= ld_data;
        end
        if (cap_fire) begin
            rsp_mem[cap_ptr[AW-1:0]] <= rsp_in;
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            rd_data <= '0;
        end else if (rd_en) begin
            rd_data <= rsp_mem[rd_addr];
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state            <= StIdle;
            {i1, i2, i3, i4} <= 4'b0000;
            done             <= 1'b0;
            err_seen         <= 1'b0;
            err_idx          <= '0;
            count            <= '0;
            vec_ptr          <= '0;
            cap_ptr          <= '0;
            vld_sr           <= '0;
        end else begin
            done <= 1'b0;

            for (int j = int'(RSP_LAT) - 1; j > 0; j--) begin
                vld_sr[j] <= vld_sr[j-1];
            end

            if (cap_fire) begin
                cap_ptr <= cap_ptr + ONE;
            end
            if (first_err) begin
                err_seen <= 1'b1;
                err_idx  <= cap_ptr[AW-1:0];
            end

            unique case (state)
                StIdle: begin
                    vld_sr[0] <= 1'b0;
                    if (clr) begin
                        count <= '0;
                    end else begin
                        if (ld_acc) begin
                            count <= count + ONE;
                        end
                        if (start) begin
                            if (count != '0 || ld_acc) begin
                                state            <= StRun;
                                {i1, i2, i3, i4} <= vec0;
                                vec_ptr          <= ONE;
                                cap_ptr          <= '0;
                                err_seen         <= 1'b0;
                                err_idx          <= '0;
                                vld_sr[0]        <= 1'b1;
                            end else begin
                                state <= StFin;
                                done  <= 1'b1;
                            end
                        end
                    end
                end
                StRun: begin
                    if (abort) begin
                        {i1, i2, i3, i4} <= 4'b0000;
                        vld_sr           <= '0;
                        state            <= StFin;
                        done             <= 1'b1;
                    end else if (vec_ptr < count) begin
                        {i1, i2, i3, i4} <= stim_mem[vec_ptr[AW-1:0]];
                        vec_ptr          <= vec_ptr + ONE;
                        vld_sr[0]        <= 1'b1;
                    end else begin
                        {i1, i2, i3, i4} <= 4'b0000;
                        vld_sr[0]        <= 1'b0;
                        state            <= StDrain;
                    end
                end
                StDrain: begin
                    vld_sr[0] <= 1'b0;
                    if (abort) begin
                        vld_sr <= '0;
                        state  <= StFin;
                        done   <= 1'b1;
                    end else if (cap_ptr == count) begin
                        state <= StFin;
                        done  <= 1'b1;
                    end
                end
                StFin: begin
                    vld_sr[0] <= 1'b0;
                    state     <= StIdle;
                end
                default: begin
                    state <= StIdle;
                end
            endcase
        end
    end

endmodule
